// File: rtl/frogger_pkg.sv
// Shared Frogger definitions: tile grid geometry, lane direction, controller
// FSM encodings and the start-column helper used to park cars.
package frogger_pkg;

   localparam int GRID_W    = 14;
   localparam int GRID_H    = 15;
   localparam int TILE_SIZE = 32;
   localparam int COORD_W   = 5;
   localparam int FIRST_ROW = 7;

   typedef enum logic {
      DIR_RIGHT = 1'b0,
      DIR_LEFT  = 1'b1
   } dir_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      FREEZE = 2'd2
   } state_t;

   // Start column of car 'car' in lane 'lane': cars evenly spaced, lanes staggered by 3.
   function automatic int start_col(input int lane, input int car, input int gap, input int grid_w);
      return (car * gap + 3 * lane) % grid_w;
   endfunction

endpackage

// File: rtl/lane_ctrl.sv
// One traffic lane: step-period counter with a period latched at every step,
// CARS_PER_LANE car columns that all move together, and combinational
// "car under pixel" / "car under frog" flags built from the registered columns.
module lane_ctrl #(
   parameter int                LANE_IDX      = 0,
   parameter frogger_pkg::dir_t DIR           = frogger_pkg::DIR_RIGHT,
   parameter int                CARS_PER_LANE = 2,
   parameter int                GRID_W        = frogger_pkg::GRID_W,
   parameter int                FIRST_ROW     = frogger_pkg::FIRST_ROW,
   parameter int                COORD_W       = frogger_pkg::COORD_W,
   parameter int                BASE_PERIOD   = 4000000,
   parameter int                PERIOD_STEP   = 300000,
   parameter int                LEVEL_STEP    = 250000,
   parameter int                MIN_PERIOD    = 500000,
   parameter int                CAR_GAP       = 7
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               idle_en,
   input  logic               run_en,
   input  logic [3:0]         level,
   input  logic [COORD_W-1:0] col,
   input  logic [COORD_W-1:0] row,
   input  logic [COORD_W-1:0] frog_x,
   input  logic [COORD_W-1:0] frog_y,
   output logic               draw,
   output logic               overlap
);
   import frogger_pkg::*;

   localparam int                 CNT_W    = $clog2(BASE_PERIOD + 1);
   localparam logic [COORD_W-1:0] LANE_ROW = COORD_W'(FIRST_ROW + LANE_IDX);
   localparam logic [COORD_W-1:0] LAST_COL = COORD_W'(GRID_W - 1);

   int                       period_int;
   logic [CNT_W-1:0]         period_next;
   logic [CNT_W-1:0]         period_reg;
   logic [CNT_W-1:0]         cnt_reg;
   logic                     step;
   logic [CARS_PER_LANE-1:0] car_draw;
   logic [CARS_PER_LANE-1:0] car_overlap;

   // Lane period for the current level: signed arithmetic, floored at MIN_PERIOD.
   always_comb begin
      period_int = BASE_PERIOD - LANE_IDX * PERIOD_STEP - int'(level) * LEVEL_STEP;
      if (period_int < MIN_PERIOD) begin
         period_int = MIN_PERIOD;
      end
      period_next = CNT_W'(period_int);
   end

   assign step = run_en && (cnt_reg == period_reg - CNT_W'(1));

   // Step counter; the period is re-latched only on reset, idle and at each step.
   always_ff @(posedge clk) begin
      if (!rst_n || idle_en) begin
         cnt_reg    <= '0;
         period_reg <= period_next;
      end else if (step) begin
         cnt_reg    <= '0;
         period_reg <= period_next;
      end else if (run_en) begin
         cnt_reg <= cnt_reg + CNT_W'(1);
      end
   end

   for (genvar gi = 0; gi < CARS_PER_LANE; gi++) begin : g_car
      localparam logic [COORD_W-1:0] START_X =
         COORD_W'(start_col(LANE_IDX, gi, CAR_GAP, GRID_W));

      logic [COORD_W-1:0] pos_reg;
      logic [COORD_W-1:0] pos_next;

      // Column after one step, wrapping at the grid edge in the lane's direction.
      always_comb begin
         pos_next = pos_reg;
         if (DIR == DIR_RIGHT) begin
            pos_next = (pos_reg == LAST_COL) ? '0 : pos_reg + COORD_W'(1);
         end else begin
            pos_next = (pos_reg == '0) ? LAST_COL : pos_reg - COORD_W'(1);
         end
      end

      // Car column: parked at its start column in reset/idle, advanced on a step.
      always_ff @(posedge clk) begin
         if (!rst_n || idle_en) begin
            pos_reg <= START_X;
         end else if (step) begin
            pos_reg <= pos_next;
         end
      end

      assign car_draw[gi]    = (row == LANE_ROW) && (col == pos_reg);
      assign car_overlap[gi] = (frog_y == LANE_ROW) && (frog_x == pos_reg);
   end

   assign draw    = |car_draw;
   assign overlap = |car_overlap;

endmodule

// File: rtl/lane_obstacle_ctrl.sv
// Multi-lane car controller: game-mode FSM, NUM_LANES lane_ctrl instances with
// alternating direction, registered per-pixel draw flag and a rising-edge
// frog-collision pulse tagged with the lowest overlapping lane.
module lane_obstacle_ctrl #(
   parameter int NUM_LANES     = 5,
   parameter int CARS_PER_LANE = 2,
   parameter int GRID_W        = frogger_pkg::GRID_W,
   parameter int FIRST_ROW     = frogger_pkg::FIRST_ROW,
   parameter int COORD_W       = frogger_pkg::COORD_W,
   parameter int BASE_PERIOD   = 4000000,
   parameter int PERIOD_STEP   = 300000,
   parameter int LEVEL_STEP    = 250000,
   parameter int MIN_PERIOD    = 500000,
   parameter int CAR_GAP       = 7,
   parameter int LANE_W        = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
   input  logic               i_Clk,
   input  logic               i_Rst_L,
   input  logic               i_Game_Active,
   input  logic               i_Freeze,
   input  logic [3:0]         i_Level,
   input  logic [COORD_W-1:0] i_Col_Count_Div,
   input  logic [COORD_W-1:0] i_Row_Count_Div,
   input  logic [COORD_W-1:0] i_Frogger_X,
   input  logic [COORD_W-1:0] i_Frogger_Y,
   output logic               o_Draw_Car,
   output logic               o_Hit,
   output logic [LANE_W-1:0]  o_Hit_Lane
);
   import frogger_pkg::*;

   state_t                state_reg;
   state_t                state_next;
   logic                  idle_en;
   logic                  run_en;
   logic [NUM_LANES-1:0]  lane_draw;
   logic [NUM_LANES-1:0]  lane_overlap;
   logic                  overlap;
   logic                  overlap_q_reg;
   logic                  rise;
   logic [LANE_W-1:0]     hit_lane_next;
   logic                  draw_reg;
   logic                  hit_reg;
   logic [LANE_W-1:0]     hit_lane_reg;

   // Game-mode state register.
   always_ff @(posedge i_Clk) begin
      if (!i_Rst_L) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Mode transitions: inactive forces IDLE, otherwise freeze selects FREEZE over RUN.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (i_Game_Active) state_next = i_Freeze ? FREEZE : RUN;
         end
         RUN: begin
            if (!i_Game_Active) state_next = IDLE;
            else if (i_Freeze)  state_next = FREEZE;
         end
         FREEZE: begin
            if (!i_Game_Active) state_next = IDLE;
            else if (!i_Freeze) state_next = RUN;
         end
         default: state_next = IDLE;
      endcase
   end

   // Lane controls decode the mode being entered so they act on this edge's inputs.
   always_comb begin
      idle_en = (state_next == IDLE);
      run_en  = (state_next == RUN);
   end

   for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      lane_ctrl #(
         .LANE_IDX      (gi),
         .DIR           ((gi % 2 == 0) ? DIR_RIGHT : DIR_LEFT),
         .CARS_PER_LANE (CARS_PER_LANE),
         .GRID_W        (GRID_W),
         .FIRST_ROW     (FIRST_ROW),
         .COORD_W       (COORD_W),
         .BASE_PERIOD   (BASE_PERIOD),
         .PERIOD_STEP   (PERIOD_STEP),
         .LEVEL_STEP    (LEVEL_STEP),
         .MIN_PERIOD    (MIN_PERIOD),
         .CAR_GAP       (CAR_GAP)
      ) u_lane (
         .clk     (i_Clk),
         .rst_n   (i_Rst_L),
         .idle_en (idle_en),
         .run_en  (run_en),
         .level   (i_Level),
         .col     (i_Col_Count_Div),
         .row     (i_Row_Count_Div),
         .frog_x  (i_Frogger_X),
         .frog_y  (i_Frogger_Y),
         .draw    (lane_draw[gi]),
         .overlap (lane_overlap[gi])
      );
   end

   assign overlap = |lane_overlap;
   assign rise    = overlap & ~overlap_q_reg;

   // Lowest-index overlapping lane wins.
   always_comb begin
      hit_lane_next = '0;
      for (int i = NUM_LANES - 1; i >= 0; i--) begin
         if (lane_overlap[i]) hit_lane_next = LANE_W'(i);
      end
   end

   // Registered draw flag and one pulse per overlap episode; no pulses while idle.
   always_ff @(posedge i_Clk) begin
      if (!i_Rst_L) begin
         draw_reg      <= 1'b0;
         hit_reg       <= 1'b0;
         hit_lane_reg  <= '0;
         overlap_q_reg <= 1'b0;
      end else begin
         draw_reg      <= |lane_draw;
         overlap_q_reg <= overlap;
         if (idle_en) begin
            hit_reg <= 1'b0;
         end else begin
            hit_reg <= rise;
            if (rise) hit_lane_reg <= hit_lane_next;
         end
      end
   end

   assign o_Draw_Car = draw_reg;
   assign o_Hit      = hit_reg;
   assign o_Hit_Lane = hit_lane_reg;

endmodule

// File: tb/tb_lane_obstacle_ctrl.sv
// Randomized and directed bench for lane_obstacle_ctrl with short sim periods,
// checked every cycle against a tile-level traffic model.
module tb_lane_obstacle_ctrl;

   localparam int NL = 5;
   localparam int NC = 2;
   localparam int GW = 14;
   localparam int FR = 7;

   logic       clk = 1'b0;
   logic       rst_l;
   logic       game_active;
   logic       freeze;
   logic [3:0] level;
   logic [4:0] col, row, frog_x, frog_y;
   logic       draw_car;
   logic       hit;
   logic [2:0] hit_lane;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;

   // Reference model state
   int mpos [NL][NC];
   int mcnt [NL];
   int mper [NL];
   bit mprev;
   bit exp_draw;
   bit exp_hit;
   int exp_lane;

   always #5 clk = ~clk;

   lane_obstacle_ctrl #(
      .NUM_LANES(NL), .CARS_PER_LANE(NC), .GRID_W(GW), .FIRST_ROW(FR), .COORD_W(5),
      .BASE_PERIOD(8), .PERIOD_STEP(1), .LEVEL_STEP(1), .MIN_PERIOD(2), .CAR_GAP(7)
   ) dut (
      .i_Clk           (clk),
      .i_Rst_L         (rst_l),
      .i_Game_Active   (game_active),
      .i_Freeze        (freeze),
      .i_Level         (level),
      .i_Col_Count_Div (col),
      .i_Row_Count_Div (row),
      .i_Frogger_X     (frog_x),
      .i_Frogger_Y     (frog_y),
      .o_Draw_Car      (draw_car),
      .o_Hit           (hit),
      .o_Hit_Lane      (hit_lane)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s cyc %0d: got %0d expected %0d", tag, cyc, got, exp);
      end
   endtask

   function automatic int lane_period(input int lane, input int lvl);
      int p;
      p = 8 - lane * 1 - lvl * 1;
      return (p < 2) ? 2 : p;
   endfunction

   function automatic void park();
      for (int i = 0; i < NL; i++) begin
         for (int k = 0; k < NC; k++) mpos[i][k] = (k * 7 + 3 * i) % GW;
         mcnt[i] = 0;
         mper[i] = lane_period(i, int'(level));
      end
   endfunction

   // One clock edge of the traffic rules, using positions as they stood before the edge.
   function automatic void model_edge();
      bit d, ov;
      int low;
      if (!rst_l) begin
         park();
         exp_draw = 0; exp_hit = 0; exp_lane = 0; mprev = 0;
         return;
      end
      d = 0; ov = 0; low = -1;
      for (int i = 0; i < NL; i++) begin
         for (int k = 0; k < NC; k++) begin
            if (mpos[i][k] == int'(col) && FR + i == int'(row)) d = 1;
            if (mpos[i][k] == int'(frog_x) && FR + i == int'(frog_y)) begin
               ov = 1;
               if (low < 0) low = i;
            end
         end
      end
      exp_draw = d;
      if (!game_active) begin
         exp_hit = 0;
      end else begin
         exp_hit = ov && !mprev;
         if (exp_hit) exp_lane = low;
      end
      mprev = ov;
      if (!game_active) begin
         park();
      end else if (!freeze) begin
         for (int i = 0; i < NL; i++) begin
            if (mcnt[i] == mper[i] - 1) begin
               for (int k = 0; k < NC; k++)
                  mpos[i][k] = (i % 2 == 0) ? (mpos[i][k] + 1) % GW : (mpos[i][k] + GW - 1) % GW;
               mcnt[i] = 0;
               mper[i] = lane_period(i, int'(level));
            end else begin
               mcnt[i]++;
            end
         end
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      cyc++;
      check("draw", 32'(draw_car), 32'(exp_draw));
      check("hit", 32'(hit), 32'(exp_hit));
      check("hit_lane", 32'(hit_lane), 32'(exp_lane));
      $display("cyc %0d rst_l=%0d act=%0d frz=%0d lvl=%0d pix=(%0d,%0d) frog=(%0d,%0d) draw=%0d hit=%0d lane=%0d",
               cyc, rst_l, game_active, freeze, level, col, row, frog_x, frog_y, draw_car, hit, hit_lane);
   endtask

   task automatic tick_n(input int n);
      for (int j = 0; j < n; j++) tick();
   endtask

   initial begin
      rst_l = 1'b0; game_active = 1'b1; freeze = 1'b0; level = 4'd0;
      col = 5'd1; row = 5'd7; frog_x = 5'd0; frog_y = 5'd0;

      // Reset state
      tick_n(2);
      check("rst_draw", 32'(draw_car), 32'd0);
      check("rst_hit", 32'(hit), 32'd0);
      check("rst_lane", 32'(hit_lane), 32'd0);

      // Lane 0 steps after 8 clocks, lane 1 after 7
      rst_l = 1'b1;
      tick_n(7);
      check("l0_not_yet", 32'(draw_car), 32'd0);
      col = 5'd2; row = 5'd8;
      tick();
      check("l1_step_p7", 32'(draw_car), 32'd1);
      col = 5'd1; row = 5'd7;
      tick();
      check("l0_step_p8", 32'(draw_car), 32'd1);

      // Level change mid-count: current step still 8, following step 5
      level = 4'd3; col = 5'd2;
      tick_n(7);
      check("lvl_cur_step8_pre", 32'(draw_car), 32'd0);
      tick();
      check("lvl_cur_step8", 32'(draw_car), 32'd1);
      col = 5'd3;
      tick_n(4);
      check("lvl_next_step5_pre", 32'(draw_car), 32'd0);
      tick();
      check("lvl_next_step5", 32'(draw_car), 32'd1);

      // Frog at (5,7): lane 0 car 0 arrives after five steps
      rst_l = 1'b0; level = 4'd0; frog_x = 5'd5; frog_y = 5'd7; col = 5'd5; row = 5'd7;
      tick();
      rst_l = 1'b1;
      tick_n(40);
      check("hit_before", 32'(hit), 32'd0);
      tick();
      check("hit_pulse", 32'(hit), 32'd1);
      check("hit_lane0", 32'(hit_lane), 32'd0);
      tick();
      check("hit_once", 32'(hit), 32'd0);

      // Freeze 20 clocks: car stays under frog, no re-pulse, count resumes afterwards
      freeze = 1'b1;
      tick_n(20);
      check("frz_draw", 32'(draw_car), 32'd1);
      check("frz_no_hit", 32'(hit), 32'd0);
      freeze = 1'b0;
      tick_n(6);
      check("resume_hold", 32'(draw_car), 32'd1);
      tick();
      check("resume_step", 32'(draw_car), 32'd0);

      // Saturated periods at level 15: frequent wraps in every lane
      level = 4'd15;
      for (int n = 0; n < 500; n++) begin
         col = 5'($urandom_range(0, 15)); row = 5'($urandom_range(5, 13));
         if ($urandom_range(0, 5) == 0) begin
            frog_x = 5'($urandom_range(0, 13)); frog_y = 5'($urandom_range(6, 12));
         end
         tick();
      end

      // Fully randomized traffic
      for (int n = 0; n < 2500; n++) begin
         rst_l       = ($urandom_range(0, 199) != 0);
         game_active = ($urandom_range(0, 39) != 0);
         freeze      = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 39) == 0) level = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 7) == 0) begin
            frog_x = 5'($urandom_range(0, 13)); frog_y = 5'($urandom_range(6, 12));
         end
         col = 5'($urandom_range(0, 15)); row = 5'($urandom_range(5, 13));
         tick();
      end

      // Idle for one clock, then reset mid-count
      rst_l = 1'b1; game_active = 1'b0; freeze = 1'b0;
      tick();
      game_active = 1'b1;
      tick_n(3);
      rst_l = 1'b0;
      tick();
      check("rst_mid_draw", 32'(draw_car), 32'd0);
      check("rst_mid_hit", 32'(hit), 32'd0);
      check("rst_mid_lane", 32'(hit_lane), 32'd0);
      rst_l = 1'b1;
      tick_n(4);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
